// File: rtl/astra_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module      : astra_pkg
// | Description : Shared constants and parser state type for the Astra core.
// | Revision    : 1.0
// +----------------------------------------------------------------------------
package astra_pkg;
  localparam logic [7:0] CMD_SYNC  = 8'hA5;
  localparam int         FRAME_LEN = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } parser_state_t;
endpackage
`default_nettype wire

// File: rtl/uart_8n1.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module      : uart_8n1
// | Description : 8N1 UART receiver and transmitter; RX is ignored while TX runs.
// | Revision    : 1.0
// +----------------------------------------------------------------------------
module uart_8n1 #(
  parameter int BAUD_DIV = 700
) (
  input  logic       clk80,
  input  logic       rst_n,
  input  logic       rx,
  output logic       tx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_ferr,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy
);
  localparam int            CW         = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] C_BIT_LAST = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] C_HALF     = CW'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t     r_rx_state;
  logic          r_rx_s1, r_rx_s2, r_rx_prev;
  logic [CW-1:0] r_rx_cnt;
  logic [2:0]    r_rx_bit;
  logic [7:0]    r_rx_sh;

  logic [8:0]    r_tx_sh;
  logic [3:0]    r_tx_bit;
  logic [CW-1:0] r_tx_cnt;

  // Synchronizers reset to the idle-high level so release never looks like a start edge
  always_ff @(posedge clk80 or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state <= RX_IDLE;
      r_rx_s1    <= 1'b1;
      r_rx_s2    <= 1'b1;
      r_rx_prev  <= 1'b1;
      r_rx_cnt   <= '0;
      r_rx_bit   <= '0;
      r_rx_sh    <= '0;
      rx_valid   <= 1'b0;
      rx_data    <= '0;
      rx_ferr    <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      rx_ferr   <= 1'b0;
      r_rx_s1   <= rx;
      r_rx_s2   <= r_rx_s1;
      r_rx_prev <= r_rx_s2;
      case (r_rx_state)
        RX_IDLE: begin
          if (r_rx_prev && !r_rx_s2 && !tx_busy) begin
            r_rx_state <= RX_START;
            r_rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (r_rx_cnt == C_HALF) begin
            r_rx_cnt <= '0;
            r_rx_bit <= '0;
            r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (r_rx_cnt == C_BIT_LAST) begin
            r_rx_cnt <= '0;
            r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
            r_rx_bit <= r_rx_bit + 3'd1;
            if (r_rx_bit == 3'd7) r_rx_state <= RX_STOP;
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (r_rx_cnt == C_BIT_LAST) begin
            r_rx_state <= RX_IDLE;
            if (r_rx_s2) begin
              rx_valid <= 1'b1;
              rx_data  <= r_rx_sh;
            end else begin
              rx_ferr  <= 1'b1;
            end
          end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
          end
        end
        default: r_rx_state <= RX_IDLE;
      endcase
    end
  end

  // Shift register holds data then the stop bit; start bit is driven on acceptance
  always_ff @(posedge clk80 or negedge rst_n) begin
    if (!rst_n) begin
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      r_tx_sh  <= '1;
      r_tx_bit <= '0;
      r_tx_cnt <= '0;
    end else if (!tx_busy) begin
      if (tx_start) begin
        tx       <= 1'b0;
        tx_busy  <= 1'b1;
        r_tx_sh  <= {1'b1, tx_data};
        r_tx_bit <= '0;
        r_tx_cnt <= '0;
      end
    end else if (r_tx_cnt == C_BIT_LAST) begin
      r_tx_cnt <= '0;
      if (r_tx_bit == 4'd9) begin
        tx_busy <= 1'b0;
        tx      <= 1'b1;
      end else begin
        tx       <= r_tx_sh[0];
        r_tx_sh  <= {1'b1, r_tx_sh[8:1]};
        r_tx_bit <= r_tx_bit + 4'd1;
      end
    end else begin
      r_tx_cnt <= r_tx_cnt + 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/astra_core.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module      : astra_core
// | Description : Dual-DAC telemetry frame generator with UART-loadable table.
// | Revision    : 1.0
// +----------------------------------------------------------------------------
module astra_core #(
  parameter int BAUD_DIV = 700,
  parameter int DAC_DIV  = 16
) (
  input  logic clk80,
  input  logic rst_n,
  output logic DAC_MODE,
  output logic DAC1_CLK,
  output logic DAC1_DB0, DAC1_DB1, DAC1_DB2, DAC1_DB3,
  output logic DAC1_DB4, DAC1_DB5, DAC1_DB6, DAC1_DB7,
  output logic DAC2_CLK,
  output logic DAC2_DB0, DAC2_DB1, DAC2_DB2, DAC2_DB3,
  output logic DAC2_DB4, DAC2_DB5, DAC2_DB6, DAC2_DB7,
  output logic SKUT_MBR,
  output logic SKUT_VI,
  input  logic UART0_RX,
  output logic UART0_TX,
  output logic UART0_dTX,
  output logic UART0_dRX
);
  import astra_pkg::*;

  localparam int            DW         = $clog2(DAC_DIV);
  localparam logic [DW-1:0] C_DIV_LAST = DW'(DAC_DIV - 1);
  localparam logic [DW-1:0] C_DIV_HALF = DW'(DAC_DIV / 2);

  logic [DW-1:0] r_div, w_div_next;
  logic [7:0]    r_idx, w_idx_next;
  logic          w_wrap;
  logic [7:0]    r_dac1, r_dac2;
  logic          r_dclk, r_mode, r_mbr, r_vi;
  logic [7:0]    r_ram [FRAME_LEN];

  parser_state_t r_state;
  logic [7:0]    r_addr, r_tx_byte;
  logic          r_tx_req, w_we;
  logic          w_rx_valid, w_rx_ferr, w_tx_busy;
  logic [7:0]    w_rx_data;

  assign w_wrap     = (r_div == C_DIV_LAST);
  assign w_div_next = w_wrap ? '0 : r_div + 1'b1;
  assign w_idx_next = r_idx + 8'd1;
  assign w_we       = w_rx_valid && (r_state == DATA);

  always_ff @(posedge clk80 or negedge rst_n) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_idx  <= 8'hFF;
      r_dac1 <= '0;
      r_dac2 <= '0;
      r_dclk <= 1'b0;
      r_mode <= 1'b0;
      r_mbr  <= 1'b0;
      r_vi   <= 1'b0;
    end else begin
      r_mode <= 1'b1;
      r_div  <= w_div_next;
      r_dclk <= (w_div_next >= C_DIV_HALF);
      if (w_wrap) begin
        r_idx  <= w_idx_next;
        r_dac1 <= r_ram[w_idx_next];
        r_dac2 <= w_idx_next;
        r_mbr  <= (w_idx_next == 8'd0);
        if (w_idx_next == 8'd0) r_vi <= ~r_vi;
      end
    end
  end

  // Same-cycle write and DAC read of one address: the read sees the old word
  always_ff @(posedge clk80) begin
    if (w_we) r_ram[r_addr] <= w_rx_data;
  end

  always_ff @(posedge clk80 or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_tx_req  <= 1'b0;
      r_tx_byte <= '0;
    end else begin
      r_tx_req <= 1'b0;
      if (w_rx_ferr) begin
        r_state <= IDLE;
      end else if (w_rx_valid) begin
        case (r_state)
          IDLE: if (w_rx_data == CMD_SYNC) r_state <= ADDR;
          ADDR: begin
            r_addr  <= w_rx_data;
            r_state <= DATA;
          end
          DATA: begin
            r_tx_req  <= 1'b1;
            r_tx_byte <= w_rx_data;
            r_state   <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  uart_8n1 #(.BAUD_DIV(BAUD_DIV)) u_uart (
    .clk80    (clk80),
    .rst_n    (rst_n),
    .rx       (UART0_RX),
    .tx       (UART0_TX),
    .rx_valid (w_rx_valid),
    .rx_data  (w_rx_data),
    .rx_ferr  (w_rx_ferr),
    .tx_start (r_tx_req),
    .tx_data  (r_tx_byte),
    .tx_busy  (w_tx_busy)
  );

  assign UART0_dTX = w_tx_busy;
  assign UART0_dRX = w_tx_busy;
  assign DAC_MODE  = r_mode;
  assign DAC1_CLK  = r_dclk;
  assign DAC2_CLK  = r_dclk;
  assign SKUT_MBR  = r_mbr;
  assign SKUT_VI   = r_vi;
  assign {DAC1_DB7, DAC1_DB6, DAC1_DB5, DAC1_DB4,
          DAC1_DB3, DAC1_DB2, DAC1_DB1, DAC1_DB0} = r_dac1;
  assign {DAC2_DB7, DAC2_DB6, DAC2_DB5, DAC2_DB4,
          DAC2_DB3, DAC2_DB2, DAC2_DB1, DAC2_DB0} = r_dac2;
endmodule
`default_nettype wire

// File: tb/tb_astra_core.sv
`default_nettype none
// +----------------------------------------------------------------------------
// | Module      : tb_astra_core
// | Description : Self-checking bench: frame timing model, UART command table.
// | Revision    : 1.0
// +----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_astra_core;
  // Short baud divisor keeps the run small; the DAC divisor is the production value
  localparam int BAUD = 40;
  localparam int DDIV = 16;

  logic clk80 = 1'b0;
  logic rst_n = 1'b0;
  logic UART0_RX = 1'b1;
  logic DAC_MODE, DAC1_CLK, DAC2_CLK, SKUT_MBR, SKUT_VI, UART0_TX, UART0_dTX, UART0_dRX;
  logic DAC1_DB0, DAC1_DB1, DAC1_DB2, DAC1_DB3, DAC1_DB4, DAC1_DB5, DAC1_DB6, DAC1_DB7;
  logic DAC2_DB0, DAC2_DB1, DAC2_DB2, DAC2_DB3, DAC2_DB4, DAC2_DB5, DAC2_DB6, DAC2_DB7;
  logic [7:0] dac1, dac2;

  always #6 clk80 = ~clk80;

  astra_core #(.BAUD_DIV(BAUD), .DAC_DIV(DDIV)) dut (
    .clk80(clk80), .rst_n(rst_n), .DAC_MODE(DAC_MODE),
    .DAC1_CLK(DAC1_CLK),
    .DAC1_DB0(DAC1_DB0), .DAC1_DB1(DAC1_DB1), .DAC1_DB2(DAC1_DB2), .DAC1_DB3(DAC1_DB3),
    .DAC1_DB4(DAC1_DB4), .DAC1_DB5(DAC1_DB5), .DAC1_DB6(DAC1_DB6), .DAC1_DB7(DAC1_DB7),
    .DAC2_CLK(DAC2_CLK),
    .DAC2_DB0(DAC2_DB0), .DAC2_DB1(DAC2_DB1), .DAC2_DB2(DAC2_DB2), .DAC2_DB3(DAC2_DB3),
    .DAC2_DB4(DAC2_DB4), .DAC2_DB5(DAC2_DB5), .DAC2_DB6(DAC2_DB6), .DAC2_DB7(DAC2_DB7),
    .SKUT_MBR(SKUT_MBR), .SKUT_VI(SKUT_VI), .UART0_RX(UART0_RX), .UART0_TX(UART0_TX),
    .UART0_dTX(UART0_dTX), .UART0_dRX(UART0_dRX)
  );

  assign dac1 = {DAC1_DB7, DAC1_DB6, DAC1_DB5, DAC1_DB4, DAC1_DB3, DAC1_DB2, DAC1_DB1, DAC1_DB0};
  assign dac2 = {DAC2_DB7, DAC2_DB6, DAC2_DB5, DAC2_DB4, DAC2_DB3, DAC2_DB2, DAC2_DB1, DAC2_DB0};

  int checks = 0;
  int errors = 0;
  logic [7:0] m_ram   [256];
  bit         m_known [256];

  typedef struct { logic [9:0] bits; int len; } echo_t;
  echo_t echo_q[$];

  typedef struct {
    string      nm;
    logic [31:0] bytes;
    int         n;
    bit         bad0;
    bit         echo;
    logic [7:0] eval;
    bit         wr;
    logic [7:0] wa;
    logic [7:0] wd;
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Frame model: sample s (0,1,2,...) lands on clock DDIV*(s+1) after release
  int t = 0;
  initial forever begin
    logic [7:0] e2;
    logic e_mbr, e_vi, e_clk, e_mode;
    int s;
    @(negedge clk80);
    if (!rst_n) t = 0; else t++;
    e_mode = (t >= 1);
    e_clk  = (t % DDIV) >= DDIV / 2;
    if (t < DDIV) begin
      e2 = 8'h00; e_mbr = 1'b0; e_vi = 1'b0;
    end else begin
      s     = t / DDIV - 1;
      e2    = 8'(s % 256);
      e_mbr = (s % 256) == 0;
      e_vi  = 1'(((s / 256) + 1) % 2);
    end
    chk("frame {mode,clk1,clk2,mbr,vi,dac2}", {DAC_MODE, DAC1_CLK, DAC2_CLK, SKUT_MBR, SKUT_VI, dac2},
        {e_mode, e_clk, e_clk, e_mbr, e_vi, e2});
    chk("dRX follows dTX", UART0_dRX, UART0_dTX);
    if (t < DDIV) chk("dac1 before first sample", dac1, 8'h00);
    else if ((t % DDIV) == 0 && m_known[e2]) chk("dac1 table", dac1, m_ram[e2]);
  end

  // Echo decoder: samples TX at bit centres counted from the dTX rise
  initial begin
    int hi;
    logic [9:0] sh;
    hi = 0; sh = '0;
    forever begin
      @(negedge clk80);
      if (UART0_dTX) begin
        for (int b = 0; b < 10; b++) if (hi == b * BAUD + BAUD / 2) sh[b] = UART0_TX;
        hi++;
      end else if (hi > 0) begin
        echo_q.push_back('{sh, hi});
        hi = 0;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      UART0_RX = f[i];
      repeat (BAUD) @(negedge clk80);
    end
  endtask

  task automatic run_cmd(input string nm, input logic [31:0] bytes, input int n, input bit bad0,
                         input bit exp_echo, input logic [7:0] eval, input bit wr,
                         input logic [7:0] wa, input logic [7:0] wd);
    int w;
    echo_t e;
    echo_q.delete();
    if (wr) m_known[wa] = 1'b0;
    for (int i = 0; i < n; i++) begin
      repeat (BAUD) @(negedge clk80);
      send_byte(bytes[31 - 8 * i -: 8], !(bad0 && i == 0));
    end
    w = 0;
    while (echo_q.size() == 0 && w < 15 * BAUD) begin
      @(negedge clk80);
      w++;
    end
    if (exp_echo) begin
      chk({nm, " echo present"}, (echo_q.size() != 0), 1);
      if (echo_q.size() != 0) begin
        e = echo_q.pop_front();
        chk({nm, " echo data"}, e.bits[8:1], eval);
        chk({nm, " echo start/stop"}, {e.bits[9], e.bits[0]}, 2'b10);
        chk({nm, " dTX width"}, e.len, 10 * BAUD);
      end
    end else begin
      chk({nm, " no echo"}, echo_q.size(), 0);
    end
    if (wr) begin
      m_ram[wa]   = wd;
      m_known[wa] = 1'b1;
    end
  endtask

  task automatic expect_at_index(input string nm, input logic [7:0] idx, input logic [7:0] exp);
    int w;
    w = 0;
    while (dac2 != idx && w < 2 * 256 * DDIV) begin
      @(negedge clk80);
      w++;
    end
    chk({nm, " index reached"}, dac2, idx);
    chk({nm, " dac1"}, dac1, exp);
  endtask

  initial begin
    int n;
    logic [7:0] a, d, j;
    tbl[0] = '{"A5 10 3C",        32'hA5103C00, 3, 1'b0, 1'b1, 8'h3C, 1'b1, 8'h10, 8'h3C};
    tbl[1] = '{"55 A5 20 7F",     32'h55A5207F, 4, 1'b0, 1'b1, 8'h7F, 1'b1, 8'h20, 8'h7F};
    tbl[2] = '{"A5 30 00",        32'hA5300000, 3, 1'b0, 1'b1, 8'h00, 1'b1, 8'h30, 8'h00};
    tbl[3] = '{"A5(ferr) 30 40",  32'hA5304000, 3, 1'b1, 1'b0, 8'h00, 1'b0, 8'h30, 8'h00};
    for (int i = 0; i < 256; i++) m_known[i] = 1'b0;

    repeat (5) @(negedge clk80);
    chk("reset TX/dTX/dRX", {UART0_TX, UART0_dTX, UART0_dRX}, 3'b100);
    #1 rst_n = 1'b1;
    repeat (4200) @(negedge clk80);

    foreach (tbl[i])
      run_cmd(tbl[i].nm, tbl[i].bytes, tbl[i].n, tbl[i].bad0, tbl[i].echo, tbl[i].eval,
              tbl[i].wr, tbl[i].wa, tbl[i].wd);
    expect_at_index("idx 10", 8'h10, 8'h3C);
    expect_at_index("idx 20", 8'h20, 8'h7F);
    expect_at_index("idx 30", 8'h30, 8'h00);

    // Short low pulse must abort at the start-bit recheck
    echo_q.delete();
    UART0_RX = 1'b0;
    repeat (12) @(negedge clk80);
    UART0_RX = 1'b1;
    repeat (2 * BAUD) @(negedge clk80);
    chk("glitch no echo", echo_q.size(), 0);
    run_cmd("post-glitch A5 60 11", 32'hA5601100, 3, 1'b0, 1'b1, 8'h11, 1'b1, 8'h60, 8'h11);

    for (int k = 0; k < 8; k++) begin
      a = 8'($urandom_range(0, 255));
      d = 8'($urandom_range(0, 255));
      j = 8'($urandom_range(0, 255));
      if (j == 8'hA5) j = 8'h5A;
      if (k % 2 == 0) run_cmd("random", {8'hA5, a, d, 8'h00}, 3, 1'b0, 1'b1, d, 1'b1, a, d);
      else            run_cmd("random+junk", {j, 8'hA5, a, d}, 4, 1'b0, 1'b1, d, 1'b1, a, d);
    end

    // Reset while the echo is on the line
    m_known[8'h70] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      repeat (BAUD) @(negedge clk80);
      send_byte(i == 0 ? 8'hA5 : (i == 1 ? 8'h70 : 8'h12), 1'b1);
    end
    n = 0;
    while (!UART0_dTX && n < 2 * BAUD) begin
      @(negedge clk80);
      n++;
    end
    chk("echo before reset", UART0_dTX, 1'b1);
    repeat (3 * BAUD) @(negedge clk80);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset UART", {UART0_TX, UART0_dTX, UART0_dRX}, 3'b100);
    chk("async reset DAC", {dac1, dac2, DAC1_CLK, DAC2_CLK, SKUT_MBR, SKUT_VI, DAC_MODE}, '0);
    m_ram[8'h70] = 8'h12;
    m_known[8'h70] = 1'b1;
    repeat (5) @(negedge clk80);
    #1 rst_n = 1'b1;
    n = 0;
    do begin
      @(negedge clk80);
      n++;
    end while (!SKUT_MBR && n < 100);
    chk("first sample latency", n, DDIV);
    chk("first sample index", dac2, 8'h00);
    repeat (12 * BAUD) @(negedge clk80);
    echo_q.delete();

    repeat (4200) @(negedge clk80);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
